// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the default byte width.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_LOAD = 2'd1;
    localparam arb_state_t ST_WAIT = 2'd2;
    localparam arb_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set request at or after i_ptr,
// wrapping modulo NUM_REQ, returned as one-hot plus binary index.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        int                 pos;
        logic [IDX_W-1:0]   sel;
        pos      = 0;
        sel      = '0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(i_ptr) + i) % NUM_REQ;
            sel = IDX_W'(pos);
            if (!o_any && i_req[sel]) begin
                o_any         = 1'b1;
                o_onehot[sel] = 1'b1;
                o_idx         = sel;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional WAIT-state abort counter enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic                          o_tx_dv,
    output logic [DATA_WIDTH-1:0]         o_tx_byte,
    input  logic                          i_tx_active,
    input  logic                          i_tx_done,
    output logic                          o_timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   byte_q, byte_d;
    logic                    dv_q, dv_d;

    logic [NUM_REQ-1:0]      pick_oh;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic [DATA_WIDTH-1:0]   pick_byte;
    logic                    tmo_hit;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req    (i_req),
        .i_ptr    (ptr_q),
        .o_onehot (pick_oh),
        .o_idx    (pick_idx),
        .o_any    (pick_any)
    );

    always_comb begin
        pick_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_oh[k]) pick_byte = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Counter restarts while in LOAD so it reads zero on the first WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_LOAD)      cnt_d = '0;
        else if (state_q == ST_WAIT) cnt_d = cnt_q + CNT_W'(1);
    end

    assign tmo_hit   = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_d = tmo_hit && !i_tx_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
    assign tmo_hit            = 1'b0;
    assign o_timeout          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        byte_d  = byte_q;
        ack_d   = '0;
        dv_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any && !i_tx_active) begin
                    state_d = ST_LOAD;
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    byte_d  = pick_byte;
                    dv_d    = 1'b1;
                end
            end
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_tx_done || tmo_hit) begin
                    state_d = ST_DONE;
                    ack_d   = gnt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_ack     = ack_q;
    assign o_tx_dv   = dv_q;
    assign o_tx_byte = byte_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one UART transmitter among `NUM_REQ` byte requesters. Sits between client logic (command parsers, status reporters, loopback echo) and the single `uart_tx` instance on the board. It captures the winning requester's byte, issues a one-cycle data-valid pulse to the transmitter, waits for transmit completion and acknowledges the requester.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: byte width presented to the transmitter.
- `TIMEOUT_CYCLES`, 65535: cycles allowed in WAIT before abort (used only with `UART_ARB_TIMEOUT_EN`), ≥ 2.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous reset, active-low.
- `i_req`  in  NUM_REQ  per-requester request level; held until own `o_ack`.
- `i_req_data`  in  NUM_REQ*DATA_WIDTH  requester k's byte at bits [k*DATA_WIDTH +: DATA_WIDTH]; stable while `i_req[k]` high.
- `o_gnt`  out  NUM_REQ  one-hot grant, held from capture until the ack cycle inclusive.
- `o_ack`  out  NUM_REQ  one-cycle pulse to the granted requester: byte finished or aborted.
- `o_tx_dv`  out  1  one-cycle start pulse to transmitter.
- `o_tx_byte`  out  DATA_WIDTH  captured byte, stable from capture through ack.
- `i_tx_active`  in  1  transmitter busy.
- `i_tx_done`  in  1  transmitter completion pulse.
- `o_timeout`  out  1  one-cycle pulse coincident with `o_ack` when the transfer aborted.

## Operation
- States: IDLE, LOAD, WAIT, DONE. Reset state IDLE.
- IDLE: if any `i_req` high and `i_tx_active` low, select the winner, register `o_gnt` and `o_tx_byte`, go to LOAD; otherwise stay.
- Round-robin: search starts at `ptr`, wrapping modulo `NUM_REQ`; first set request wins. `ptr` resets to 0 and becomes (granted index + 1) mod `NUM_REQ` on the DONE cycle.
- LOAD: `o_tx_dv`=1 for exactly this cycle; go to WAIT.
- WAIT: on `i_tx_done`, go to DONE. `i_tx_done` in any other state is ignored.
- DONE: `o_ack[g]`=1 for this cycle; `o_gnt` cleared at exit; return to IDLE.
- Requesters drop `i_req` on the edge ending their ack cycle. A request still high in the following IDLE cycle is a new byte.
- Changes to `i_req` or `i_req_data` after capture do not affect the transfer in flight.
- Reset mid-transfer: all state clears immediately. No ack is issued for the aborted byte, and `ptr` returns to 0.
- Reset values: `o_gnt`=0, `o_ack`=0, `o_tx_dv`=0, `o_tx_byte`=0, `o_timeout`=0.

## Timing
- All outputs are registered.
- Request seen in IDLE at cycle 0: `o_gnt`/`o_tx_byte` valid in cycle 1, with `o_tx_dv` high in cycle 1 (LOAD).
- `i_tx_done` high in cycle n (WAIT) gives `o_ack` high in cycle n+1. The earliest next capture is in cycle n+2.
- Back-to-back throughput is one byte per (transmitter frame + 3) cycles.
- `i_tx_active` high holds the arbiter in IDLE. It does not affect LOAD, WAIT or DONE.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - 16-bit-min counter, sized `$clog2(TIMEOUT_CYCLES+1)`, clears on WAIT entry and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES-1` without `i_tx_done`, go to DONE with `o_ack[g]` and `o_timeout` both pulsed. `ptr` advances as normal.
- Undefined: no counter; WAIT waits indefinitely; `o_timeout` tied 0.

## Structure
- Shared package `uart_pkg`: state encoding typedef (IDLE/LOAD/WAIT/DONE) and the `DATA_WIDTH` default constant.
- One sub-module, `uart_rr_pick`: combinational, takes request vector and `ptr`, returns one-hot winner plus its binary index.

## Test plan
- Single request: `i_req`=4'b0100, data[2]=8'hA5, `i_tx_done` 20 cycles after `o_tx_dv`.
  - Expect `o_gnt`=4'b0100, one `o_tx_dv` pulse with `o_tx_byte`=8'hA5, then `o_ack`=4'b0100 one cycle after done.
- All four requesting continuously from reset: grants in order 0,1,2,3,0; every byte matches its requester; never two `o_tx_dv` pulses without an intervening ack.
- Held off by busy: `i_tx_active`=1 for 50 cycles with `i_req`=4'b0001 gives no `o_tx_dv` until 1 cycle after `i_tx_active` falls.
- Reset mid-transfer: `i_rst_n` low during WAIT clears all outputs asynchronously. After release, with `i_req`=4'b1010, requester 1 wins (`ptr`=0).
- Timeout, macro on with `TIMEOUT_CYCLES`=10 and no `i_tx_done`:
  - `o_ack` and `o_timeout` pulse together 10 cycles after WAIT entry.
  - Macro off: no ack ever issued.
- Data change after capture: alter data[0] from 8'h3C to 8'hFF one cycle after grant; `o_tx_byte` stays 8'h3C.
